// File: rtl/iram_loader.sv
// Instruction RAM with a byte-serial program loader (MSB first) and a latency-1 fetch port.
// Define IRAM_ALIGN_CHECK_EN to reject misaligned fetches with Inst=0 and a one-cycle AddrErr.
module iram_loader #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IRead,
    input  logic [31:0] Addr,
    output logic [31:0] Inst,
    input  logic        LdStart,
    input  logic        LdValid,
    input  logic [7:0]  LdByte,
    input  logic        LdEnd,
    output logic        LdReady,
    output logic        CpuHold,
    output logic        AddrErr
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, FULL} state_t;

    state_t                r_state;
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [1:0]            r_bc;
    logic [31:0]           r_asm;
    logic [31:0]           r_inst;
    logic                  r_addr_err;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic        w_take;
    logic        w_word_done;
    logic        w_last;
    logic        w_we;
    logic [1:0]  w_bc_next;
    logic [1:0]  w_bc_after;
    logic [31:0] w_asm_next;
    logic [31:0] w_flush_word;
    logic [31:0] w_wdata;
    logic        w_out_of_range;
    logic        w_misaligned;

    assign w_take      = (r_state == LOAD) && LdValid;
    assign w_asm_next  = {r_asm[23:0], LdByte};
    assign w_bc_next   = r_bc + 2'd1;
    assign w_bc_after  = w_take ? w_bc_next : r_bc;
    assign w_word_done = w_take && (r_bc == 2'd3);
    assign w_last      = &r_wp;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_flush_word = r_asm;
        case (r_bc)
            2'd1:    w_flush_word = {r_asm[7:0], 24'h0};
            2'd2:    w_flush_word = {r_asm[15:0], 16'h0};
            2'd3:    w_flush_word = {r_asm[23:0], 8'h0};
            default: w_flush_word = r_asm;
        endcase
    end

    // Reset discards any word in flight, including one completing on the reset cycle.
    assign w_we    = !Reset && (w_word_done || (r_state == FLUSH));
    assign w_wdata = (r_state == FLUSH) ? w_flush_word : w_asm_next;

    assign w_out_of_range = (Addr[31:DEPTH_LOG2+2] != '0);
`ifdef IRAM_ALIGN_CHECK_EN
    assign w_misaligned = (Addr[1:0] != 2'b00);
`else
    logic w_addr_lsb_unused;
    assign w_addr_lsb_unused = ^Addr[1:0];
    assign w_misaligned      = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_bc    <= '0;
            r_asm   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (LdStart) begin
                        r_state <= LOAD;
                        r_wp    <= '0;
                        r_bc    <= '0;
                        r_asm   <= '0;
                    end
                end
                LOAD: begin
                    if (w_take) begin
                        r_asm <= w_asm_next;
                        r_bc  <= w_bc_next;
                    end
                    if (w_word_done)
                        r_wp <= r_wp + DEPTH_LOG2'(1);
                    if (LdEnd)
                        r_state <= (w_bc_after == 2'd0) ? IDLE : FLUSH;
                    else if (w_word_done && w_last)
                        r_state <= FULL;
                end
                // The load has already ended here, so a flush into the last word still returns to IDLE.
                FLUSH: begin
                    r_wp    <= r_wp + DEPTH_LOG2'(1);
                    r_bc    <= '0;
                    r_state <= IDLE;
                end
                FULL: begin
                    if (LdEnd)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM and the program survives Reset.
    always_ff @(posedge Clk) begin
        if (w_we)
            r_mem[r_wp] <= w_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_inst     <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            if (IRead) begin
                if ((r_state != IDLE) || w_out_of_range) begin
                    r_inst <= '0;
                end else if (w_misaligned) begin
                    r_inst     <= '0;
                    r_addr_err <= 1'b1;
                end else begin
                    r_inst <= r_mem[Addr[DEPTH_LOG2+1:2]];
                end
            end
        end
    end

    assign Inst    = r_inst;
    assign AddrErr = r_addr_err;
    assign LdReady = (r_state == LOAD);
    assign CpuHold = (r_state != IDLE) || Reset;

endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, log2 of the instruction RAM depth in 32-bit words (256 words).
REQ-002 Port: Clk  in  1  the single clock; all state updates on the posedge.
REQ-003 Port: Reset  in  1  reset, synchronous and active-high.
REQ-004 Port: IRead  in  1  fetch read strobe; a read is requested when it is high at a posedge.
REQ-005 Port: Addr  in  32  fetch byte address (PC).
REQ-006 Port: Inst  out  32  registered instruction returned to fetch.
REQ-007 Port: LdStart  in  1  one-cycle pulse that begins a program load.
REQ-008 Port: LdValid  in  1  LdByte is valid this cycle.
REQ-009 Port: LdByte  in  8  program byte, most significant byte of each word first.
REQ-010 Port: LdEnd  in  1  one-cycle pulse that terminates a load.
REQ-011 Port: LdReady  out  1  the loader accepts a byte this cycle.
REQ-012 Port: CpuHold  out  1  high holds the core in reset while a load is in progress.
REQ-013 Port: AddrErr  out  1  one-cycle misaligned-fetch flag.

Function
REQ-014 States: IDLE, LOAD, FLUSH, FULL.
REQ-015 IDLE with LdStart -> LOAD; entry clears the word pointer WP, byte count BC and the assembly register ASM.
REQ-016 LOAD: LdReady=1, and a byte is accepted when LdValid is high.
REQ-017 Accepted byte: ASM <= {ASM[23:0],LdByte} and BC increments.
REQ-018 On the 4th byte (BC==3), the assembled word is written to mem[WP] in the same cycle, WP increments, and BC clears.
REQ-019 LOAD with LdEnd and BC==0 -> IDLE.
REQ-020 LOAD with LdEnd and BC!=0 -> FLUSH.
REQ-021 If LdValid and LdEnd occur in the same cycle, the byte is accepted first and BC is evaluated after that byte.
REQ-022 FLUSH lasts one cycle: it left-justifies the partial word, zero-pads the low bytes, writes it to mem[WP], then -> IDLE.
REQ-023 If the write of word index 2^DEPTH_LOG2-1 completes, the state -> FULL (no wrap).
REQ-024 FULL: LdReady=0 and bytes are ignored; LdEnd -> IDLE.
REQ-025 LdStart in any state other than IDLE is ignored.
REQ-026 CpuHold=1 whenever state!=IDLE or Reset is high; it is driven combinationally from the state.
REQ-027 Read, latency 1: at a posedge with IRead=1, Inst <= mem[Addr[DEPTH_LOG2+1:2]].
REQ-028 With IRead=0, Inst holds its value.
REQ-029 Inst <= 0 (NOP) if a read occurs while state!=IDLE.
REQ-030 Inst <= 0 (NOP) if any bit of Addr[31:DEPTH_LOG2+2] is set (out of range); AddrErr is not raised in this case.
REQ-031 LdReady=0 in IDLE, FLUSH and FULL.
REQ-032 The memory contents are not initialised by reset and survive reset.

Reset
REQ-033 Reset: state=IDLE, WP=0, BC=0, ASM=0, Inst=0, AddrErr=0.
REQ-034 Reset asserted in LOAD or FLUSH aborts the load; any partial word is discarded and not written.
REQ-035 Reset has priority over LdStart, LdEnd and IRead in the same cycle.

Configuration
REQ-036 The macro IRAM_ALIGN_CHECK_EN selects the misaligned-fetch check.
REQ-037 With IRAM_ALIGN_CHECK_EN defined, a read with Addr[1:0]!=0 returns Inst=0 and asserts AddrErr for exactly that cycle (same latency as Inst).
REQ-038 Without IRAM_ALIGN_CHECK_EN, Addr[1:0] is ignored and AddrErr is tied to 0.

Verification
REQ-039 Full load: LdStart; bytes 12 34 56 78 AA BB CC DD; LdEnd -> mem[0]=0x12345678, mem[1]=0xAABBCCDD; CpuHold falls the cycle after LdEnd.
REQ-040 Partial-word flush: load bytes 01 02 03 with LdEnd on the third byte -> one FLUSH cycle, mem[0]=0x01020300, then IDLE.
REQ-041 Read latency: after the REQ-039 load, IRead=1 with Addr=0x4 -> Inst=0xAABBCCDD one cycle later; then IRead=0 -> Inst holds. Addr=0x400 -> Inst=0.
REQ-042 Overflow: stream 1025 bytes -> FULL after byte 1024, LdReady=0, mem[255] holds bytes 1021-1024, and byte 1025 is ignored.
REQ-043 Reset mid-word: Reset after 2 bytes into word 5 -> IDLE, CpuHold=0, mem[5] unchanged; a new load starts at WP=0.
REQ-044 Misaligned fetch: IRead=1 with Addr=0x6 -> with IRAM_ALIGN_CHECK_EN: Inst=0 and a 1-cycle AddrErr pulse; without it: Inst=mem[1], AddrErr=0.
